// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter and its result FIFO.
package wb_port_arbiter_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_A,
    GNT_B
  } grant_e;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Requester handshakes and register-file write signals of the write-port arbiter.
interface wb_port_arbiter_if;
  import wb_port_arbiter_pkg::*;

  logic                  a_valid;
  logic [REG_ADDR_W-1:0] a_addr;
  logic [XLEN-1:0]       a_data;
  logic                  a_stall;
  logic                  b_valid;
  logic                  b_ready;
  logic [REG_ADDR_W-1:0] b_addr;
  logic [XLEN-1:0]       b_data;
  logic                  rf_wren;
  logic [REG_ADDR_W-1:0] rf_addr_w;
  logic [XLEN-1:0]       rf_data_w;
  logic [NUM_REGS-1:0]   b_pending;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_stall, b_ready, rf_wren, rf_addr_w, rf_data_w, b_pending
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_stall, b_ready, rf_wren, rf_addr_w, rf_data_w, b_pending
  );

endinterface

// File: rtl/wb_port_arbiter_fifo.sv
// Synchronous FIFO of write-back requests; pointers carry a wrap bit to tell full from empty.
module wb_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic    clk,
  input  logic    aclr,
  input  logic    push,
  input  wb_req_t push_data,
  input  logic    pop,
  output logic    full,
  output logic    empty,
  output wb_req_t head
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  wb_req_t     mem_q [DEPTH];
  wb_req_t     mem_d [DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push && !full) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback (A) has priority, buffered
// long-latency results (B) are forced through after MAX_WAIT lost cycles.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned MAX_WAIT   = 4
) (
  input  logic              clk,
  input  logic              aclr,
  wb_port_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [3:0]  MAX_WAIT_L = 4'(MAX_WAIT);

  logic    a_req, b_req, force_b;
  grant_e  gnt;
  logic    push, pop;
  logic    fifo_full, fifo_empty;
  wb_req_t fifo_head, push_req;

  logic [3:0]            wait_q, wait_d;
  logic                  rf_wren_q, rf_wren_d;
  logic [REG_ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [XLEN-1:0]       rf_data_q, rf_data_d;
  logic [CNT_W-1:0]      pend_cnt_q [NUM_REGS];
  logic [CNT_W-1:0]      pend_cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0]   pend_vec;

  assign push_req = '{addr: bus.b_addr, data: bus.b_data};

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .aclr      (aclr),
    .push      (push),
    .push_data (push_req),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  always_comb begin
    a_req   = bus.a_valid && (bus.a_addr != '0);
    b_req   = !fifo_empty;
    force_b = a_req && b_req && (wait_q == MAX_WAIT_L);

    gnt = GNT_NONE;
    if (b_req && (!a_req || force_b)) begin
      gnt = GNT_B;
    end else if (a_req) begin
      gnt = GNT_A;
    end

    pop  = (gnt == GNT_B);
    // Readiness comes from the current count only, so a same-cycle pop never frees a slot.
    push = bus.b_valid && !fifo_full && (bus.b_addr != '0);

    wait_d = wait_q;
    if (fifo_empty || (gnt == GNT_B)) begin
      wait_d = '0;
    end else if (a_req) begin
      wait_d = wait_q + 4'd1;
    end

    rf_wren_d = (gnt != GNT_NONE);
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    case (gnt)
      GNT_A: begin
        rf_addr_d = bus.a_addr;
        rf_data_d = bus.a_data;
      end
      GNT_B: begin
        rf_addr_d = fifo_head.addr;
        rf_data_d = fifo_head.data;
      end
      default: ;
    endcase
  end

  // Per-register occupancy counts; a matching push and pop in one cycle cancel out.
  always_comb begin
    pend_cnt_d = pend_cnt_q;
    pend_vec   = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if ((push && (bus.b_addr == REG_ADDR_W'(i))) &&
          !(pop && (fifo_head.addr == REG_ADDR_W'(i)))) begin
        pend_cnt_d[i] = pend_cnt_q[i] + CNT_W'(1);
      end else if (!(push && (bus.b_addr == REG_ADDR_W'(i))) &&
                   (pop && (fifo_head.addr == REG_ADDR_W'(i)))) begin
        pend_cnt_d[i] = pend_cnt_q[i] - CNT_W'(1);
      end
      pend_vec[i] = (pend_cnt_q[i] != '0);
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      wait_q    <= '0;
      rf_wren_q <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        pend_cnt_q[i] <= '0;
      end
    end else begin
      wait_q     <= wait_d;
      rf_wren_q  <= rf_wren_d;
      rf_addr_q  <= rf_addr_d;
      rf_data_q  <= rf_data_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  assign bus.a_stall   = force_b;
  assign bus.b_ready   = !fifo_full;
  assign bus.rf_wren   = rf_wren_q;
  assign bus.rf_addr_w = rf_addr_q;
  assign bus.rf_data_w = rf_data_q;
  assign bus.b_pending = pend_vec;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter (FIFO_DEPTH=2, MAX_WAIT=4) with hand-computed expectations.
module tb_wb_port_arbiter;

  logic clk;
  logic aclr;
  int   n_tests;
  int   n_fail;

  wb_port_arbiter_if bus ();

  wb_port_arbiter #(
    .FIFO_DEPTH (2),
    .MAX_WAIT   (4)
  ) dut (
    .clk  (clk),
    .aclr (aclr),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rf(input string tag, input logic wren, input logic [4:0] addr,
                        input logic [31:0] data);
    chk({tag, "_wren"}, {31'd0, bus.rf_wren}, {31'd0, wren});
    chk({tag, "_addr"}, {27'd0, bus.rf_addr_w}, {27'd0, addr});
    chk({tag, "_data"}, bus.rf_data_w, data);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    aclr = 1'b1;
    bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0;
    #2;
    chk_rf("rst", 1'b0, 5'd0, 32'h0);
    chk("rst_b_ready", {31'd0, bus.b_ready}, 32'd1);
    chk("rst_pending", bus.b_pending, 32'h0);
    chk("rst_a_stall", {31'd0, bus.a_stall}, 32'd0);
    @(negedge clk);
    aclr = 1'b0;
    tick();

    // A only
    bus.a_valid = 1'b1; bus.a_addr = 5'd5; bus.a_data = 32'hDEADBEEF;
    #1;
    chk("a_only_stall", {31'd0, bus.a_stall}, 32'd0);
    tick();
    chk_rf("a_only", 1'b1, 5'd5, 32'hDEADBEEF);
    bus.a_valid = 1'b0;
    tick();
    chk("a_only_idle", {31'd0, bus.rf_wren}, 32'd0);

    // Zero-register filtering on both sides
    bus.a_valid = 1'b1; bus.a_addr = 5'd0; bus.a_data = 32'h123;
    bus.b_valid = 1'b1; bus.b_addr = 5'd0; bus.b_data = 32'h55;
    #1;
    chk("zero_stall", {31'd0, bus.a_stall}, 32'd0);
    chk("zero_b_ready", {31'd0, bus.b_ready}, 32'd1);
    tick();
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    chk("zero_wren1", {31'd0, bus.rf_wren}, 32'd0);
    chk("zero_pending", bus.b_pending, 32'h0);
    tick();
    chk("zero_wren2", {31'd0, bus.rf_wren}, 32'd0);

    // B only: back-to-back pushes, each drained the cycle after it lands
    bus.b_valid = 1'b1; bus.b_addr = 5'd7; bus.b_data = 32'h11;
    tick();
    chk("b_pend7", bus.b_pending, 32'h0000_0080);
    chk("b_no_write_yet", {31'd0, bus.rf_wren}, 32'd0);
    bus.b_addr = 5'd9; bus.b_data = 32'h22;
    #1;
    chk("b_ready_one", {31'd0, bus.b_ready}, 32'd1);
    tick();
    bus.b_valid = 1'b0;
    chk_rf("b_w7", 1'b1, 5'd7, 32'h11);
    chk("b_pend9", bus.b_pending, 32'h0000_0200);
    tick();
    chk_rf("b_w9", 1'b1, 5'd9, 32'h22);
    chk("b_pend_clr", bus.b_pending, 32'h0);
    tick();
    chk("b_idle", {31'd0, bus.rf_wren}, 32'd0);

    // Starvation: one B entry against continuous A traffic
    bus.a_valid = 1'b1; bus.a_addr = 5'd3; bus.a_data = 32'hA000_0000;
    bus.b_valid = 1'b1; bus.b_addr = 5'd12; bus.b_data = 32'hCC;
    tick();
    bus.b_valid = 1'b0;
    chk_rf("st_a0", 1'b1, 5'd3, 32'hA000_0000);
    chk("st_pend12", bus.b_pending, 32'h0000_1000);
    for (int k = 1; k <= 4; k++) begin
      bus.a_data = 32'hA000_0000 + k;
      #1;
      chk($sformatf("st_nostall%0d", k), {31'd0, bus.a_stall}, 32'd0);
      tick();
      chk_rf($sformatf("st_a%0d", k), 1'b1, 5'd3, 32'hA000_0000 + k);
    end
    bus.a_data = 32'hA000_0005;
    #1;
    chk("st_stall", {31'd0, bus.a_stall}, 32'd1);
    tick();
    chk_rf("st_b12", 1'b1, 5'd12, 32'hCC);
    chk("st_pend_clr", bus.b_pending, 32'h0);
    chk("st_after_stall", {31'd0, bus.a_stall}, 32'd0);
    tick();
    chk_rf("st_a5", 1'b1, 5'd3, 32'hA000_0005);

    // Full with pop: blocked enqueue retried the next cycle, nothing lost or doubled
    bus.a_data = 32'hB000_0000;
    bus.b_valid = 1'b1; bus.b_addr = 5'd14; bus.b_data = 32'h41;
    tick();
    bus.b_addr = 5'd15; bus.b_data = 32'h42;
    #1;
    chk("fp_ready_one", {31'd0, bus.b_ready}, 32'd1);
    tick();
    bus.b_addr = 5'd16; bus.b_data = 32'h43;
    chk("fp_pend_full", bus.b_pending, 32'h0000_C000);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("fp_full%0d", k), {31'd0, bus.b_ready}, 32'd0);
      chk($sformatf("fp_nostall%0d", k), {31'd0, bus.a_stall}, 32'd0);
      tick();
      chk($sformatf("fp_a_addr%0d", k), {27'd0, bus.rf_addr_w}, 32'd3);
    end
    #1;
    chk("fp_stall", {31'd0, bus.a_stall}, 32'd1);
    chk("fp_full_pop", {31'd0, bus.b_ready}, 32'd0);
    tick();
    chk_rf("fp_b14", 1'b1, 5'd14, 32'h41);
    chk("fp_pend15", bus.b_pending, 32'h0000_8000);
    #1;
    chk("fp_ready_again", {31'd0, bus.b_ready}, 32'd1);
    chk("fp_a_resume", {31'd0, bus.a_stall}, 32'd0);
    tick();
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    chk_rf("fp_a", 1'b1, 5'd3, 32'hB000_0000);
    chk("fp_pend1516", bus.b_pending, 32'h0001_8000);
    tick();
    chk_rf("fp_b15", 1'b1, 5'd15, 32'h42);
    chk("fp_pend16", bus.b_pending, 32'h0001_0000);
    tick();
    chk_rf("fp_b16", 1'b1, 5'd16, 32'h43);
    chk("fp_pend_clr", bus.b_pending, 32'h0);
    tick();
    chk("fp_idle", {31'd0, bus.rf_wren}, 32'd0);

    // Asynchronous reset mid-burst with two entries queued
    bus.a_valid = 1'b1; bus.a_addr = 5'd3; bus.a_data = 32'hC0;
    bus.b_valid = 1'b1; bus.b_addr = 5'd20; bus.b_data = 32'h61;
    tick();
    bus.b_addr = 5'd21; bus.b_data = 32'h62;
    tick();
    bus.b_valid = 1'b0;
    chk("mr_pend", bus.b_pending, 32'h0030_0000);
    chk("mr_full", {31'd0, bus.b_ready}, 32'd0);
    #3;
    aclr = 1'b1;
    #1;
    chk_rf("mr", 1'b0, 5'd0, 32'h0);
    chk("mr_b_ready", {31'd0, bus.b_ready}, 32'd1);
    chk("mr_pending", bus.b_pending, 32'h0);
    chk("mr_a_stall", {31'd0, bus.a_stall}, 32'd0);
    bus.a_valid = 1'b0;
    @(negedge clk);
    aclr = 1'b0;
    tick();
    chk("mr_no_write", {31'd0, bus.rf_wren}, 32'd0);
    tick();
    chk("mr_no_write2", {31'd0, bus.rf_wren}, 32'd0);
    chk("mr_pending2", bus.b_pending, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
